// File: rtl/trilat_pkg.sv
// Shared definitions for the trilateration point-selection stage.
// Width helpers let every module derive its datapath sizes from N.
package trilat_pkg;

  localparam int N_DEFAULT = 8;

  // Default-N widths; the functions below give the same values for any N.
  localparam int DIFF_W = N_DEFAULT + 3;
  localparam int SQ_W   = 2 * N_DEFAULT + 6;
  localparam int SUM_W  = 2 * N_DEFAULT + 7;
  localparam int ERR_W  = 2 * N_DEFAULT + 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_CMP,
    S_OUT
  } state_t;

  function automatic int diffWidth(input int n);
    return n + 3;
  endfunction

  function automatic int sqWidth(input int n);
    return 2 * n + 6;
  endfunction

  function automatic int sumWidth(input int n);
    return 2 * n + 7;
  endfunction

  function automatic int errWidth(input int n);
    return 2 * n + 7;
  endfunction

endpackage

// File: rtl/sq_err_unit.sv
// Shared squarer plus product registers and absolute-residual logic.
// One product is registered per enabled cycle, selected by the step index.
import trilat_pkg::*;

module sq_err_unit #(
  parameter int N = N_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_mulEn,
  input  logic [2:0]                 i_step,
  input  logic signed [N+1:0]        i_x1,
  input  logic signed [N+1:0]        i_y1,
  input  logic signed [N+1:0]        i_x2,
  input  logic signed [N+1:0]        i_y2,
  input  logic signed [N-1:0]        i_xM,
  input  logic signed [N-1:0]        i_yM,
  input  logic [N:0]                 i_rM,
  output logic [errWidth(N)-1:0]     o_err1,
  output logic [errWidth(N)-1:0]     o_err2
);

  localparam int DW   = diffWidth(N);
  localparam int SW   = sqWidth(N);
  localparam int SUMW = sumWidth(N);
  localparam int EW   = errWidth(N);
  localparam int RSW  = 2 * N + 2;
  localparam int RESW = 2 * N + 8;

  logic signed [DW-1:0]   w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [DW-1:0]   w_mulOp;
  logic signed [SW-1:0]   w_product;
  logic [SW-1:0]          r_sqDx1, r_sqDy1, r_sqDx2, r_sqDy2;
  logic [RSW-1:0]         r_sqR;
  logic [SUMW-1:0]        w_sum1, w_sum2;
  logic signed [RESW-1:0] w_res1, w_res2;
  logic signed [RESW-1:0] w_abs1, w_abs2;

  assign w_dx1 = {i_x1[N+1], i_x1} - {{3{i_xM[N-1]}}, i_xM};
  assign w_dy1 = {i_y1[N+1], i_y1} - {{3{i_yM[N-1]}}, i_yM};
  assign w_dx2 = {i_x2[N+1], i_x2} - {{3{i_xM[N-1]}}, i_xM};
  assign w_dy2 = {i_y2[N+1], i_y2} - {{3{i_yM[N-1]}}, i_yM};

  // Step 5 keeps rM on the multiplier but writes nothing back.
  always_comb begin
    w_mulOp = '0;
    case (i_step)
      3'd0:    w_mulOp = w_dx1;
      3'd1:    w_mulOp = w_dy1;
      3'd2:    w_mulOp = w_dx2;
      3'd3:    w_mulOp = w_dy2;
      default: w_mulOp = {2'b00, i_rM};
    endcase
  end

  assign w_product = w_mulOp * w_mulOp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sqDx1 <= '0;
      r_sqDy1 <= '0;
      r_sqDx2 <= '0;
      r_sqDy2 <= '0;
      r_sqR   <= '0;
    end else if (i_mulEn) begin
      case (i_step)
        3'd0:    r_sqDx1 <= w_product;
        3'd1:    r_sqDy1 <= w_product;
        3'd2:    r_sqDx2 <= w_product;
        3'd3:    r_sqDy2 <= w_product;
        3'd4:    r_sqR   <= w_product[RSW-1:0];
        default: ;
      endcase
    end
  end

  assign w_sum1 = {1'b0, r_sqDx1} + {1'b0, r_sqDy1};
  assign w_sum2 = {1'b0, r_sqDx2} + {1'b0, r_sqDy2};

  // Residual is widened by one bit so the signed difference never wraps.
  assign w_res1 = $signed({1'b0, w_sum1}) - $signed({6'b0, r_sqR});
  assign w_res2 = $signed({1'b0, w_sum2}) - $signed({6'b0, r_sqR});

  assign w_abs1 = w_res1[RESW-1] ? -w_res1 : w_res1;
  assign w_abs2 = w_res2[RESW-1] ? -w_res2 : w_res2;

  assign o_err1 = w_abs1[EW-1:0];
  assign o_err2 = w_abs2[EW-1:0];

endmodule

// File: rtl/intersection_select.sv
// Picks whichever circle-intersection candidate best fits the third anchor.
// Handshaked: capture, six shared-multiplier steps, compare, hold result.
import trilat_pkg::*;

module intersection_select #(
  parameter int N = N_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [N+1:0]    x1P,
  input  logic signed [N+1:0]    y1P,
  input  logic signed [N+1:0]    x2P,
  input  logic signed [N+1:0]    y2P,
  input  logic signed [N-1:0]    xM,
  input  logic signed [N-1:0]    yM,
  input  logic [N:0]             rM,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [N+1:0]    xS,
  output logic signed [N+1:0]    yS,
  output logic                   sel,
  output logic [errWidth(N)-1:0] err
);

  localparam int EW = errWidth(N);

  state_t              r_state;
  logic [2:0]          r_step;
  logic                r_inReady;
  logic                r_outValid;
  logic signed [N+1:0] r_x1, r_y1, r_x2, r_y2;
  logic signed [N-1:0] r_xM, r_yM;
  logic [N:0]          r_rM;
  logic signed [N+1:0] r_xS, r_yS;
  logic                r_sel;
  logic [EW-1:0]       r_err;
  logic                w_mulEn;
  logic [EW-1:0]       w_err1, w_err2;

  assign w_mulEn = (r_state == S_MUL);

  sq_err_unit #(.N(N)) u_sqErr (
    .clk     (clk),
    .rst     (rst),
    .i_mulEn (w_mulEn),
    .i_step  (r_step),
    .i_x1    (r_x1),
    .i_y1    (r_y1),
    .i_x2    (r_x2),
    .i_y2    (r_y2),
    .i_xM    (r_xM),
    .i_yM    (r_yM),
    .i_rM    (r_rM),
    .o_err1  (w_err1),
    .o_err2  (w_err2)
  );

  // in_ready is registered so it stays low through reset and rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_xM       <= '0;
      r_yM       <= '0;
      r_rM       <= '0;
      r_xS       <= '0;
      r_yS       <= '0;
      r_sel      <= 1'b0;
      r_err      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_inReady) begin
            r_x1      <= x1P;
            r_y1      <= y1P;
            r_x2      <= x2P;
            r_y2      <= y2P;
            r_xM      <= xM;
            r_yM      <= yM;
            r_rM      <= rM;
            r_step    <= '0;
            r_inReady <= 1'b0;
            r_state   <= S_MUL;
          end else begin
            r_inReady <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_step == 3'd5) begin
            r_step  <= '0;
            r_state <= S_CMP;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        S_CMP: begin
          // Ties favour point 1.
          if (w_err1 <= w_err2) begin
            r_xS  <= r_x1;
            r_yS  <= r_y1;
            r_sel <= 1'b0;
            r_err <= w_err1;
          end else begin
            r_xS  <= r_x2;
            r_yS  <= r_y2;
            r_sel <= 1'b1;
            r_err <= w_err2;
          end
          r_outValid <= 1'b1;
          r_state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign xS        = r_xS;
  assign yS        = r_yS;
  assign sel       = r_sel;
  assign err       = r_err;

endmodule

// File: doc/intersection_select.md
INTERSECTION_SELECT -- requirements
Module: intersection_select

Interface
REQ-001 Parameter: N, default 8, anchor coordinate width; all other widths derive from N.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  candidate pair and anchor present.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 x1P, y1P, x2P, y2P  input  N+2 each, signed  the two circle-intersection candidates from the upstream intersection stage.
REQ-007 xM, yM  input  N each, signed  third anchor centre.
REQ-008 rM  input  N+1, unsigned  third anchor range.
REQ-009 out_valid  output  1  result valid, held until accepted.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 xS, yS  output  N+2 each, signed  selected point.
REQ-012 sel  output  1  0 = point 1 chosen, 1 = point 2 chosen.
REQ-013 err  output  2N+7, unsigned  residual of the chosen point.

Function
REQ-014 Accept on a rising edge with in_valid=1 and in_ready=1; capture all inputs into registers; later input changes are ignored until the next acceptance.
REQ-015 For each candidate i, err_i SHALL be |(xi-xM)^2 + (yi-yM)^2 - rM^2|, computed exactly without overflow or saturation.
REQ-016 Differences SHALL be N+3 bits signed; squares 2N+6 unsigned; sum 2N+7; rM^2 2N+2; subtraction SHALL be done in 2N+8 signed before taking the absolute value.
REQ-017 One shared signed multiplier, one product per cycle, six products total: dx1^2, dy1^2, dx2^2, dy2^2, rM^2, and one spare slot reusing rM^2 (step 5 is a no-op).
REQ-018 FSM states: IDLE -> MUL (step counter 0..5) -> CMP -> OUT -> IDLE.
REQ-019 IDLE -> MUL on acceptance; MUL advances the step each cycle; after step 5, MUL -> CMP; CMP -> OUT unconditionally; OUT -> IDLE on out_valid and out_ready.
REQ-020 out_valid SHALL rise exactly 7 clock edges after the acceptance edge.
REQ-021 Selection: err1 <= err2 selects point 1 (sel=0). Ties SHALL go to point 1.
REQ-022 While out_valid=1 and out_ready=0, xS, yS, sel and err SHALL remain stable, and in_ready SHALL stay 0.
REQ-023 in_valid pulses outside IDLE SHALL be ignored and have no side effects.
REQ-024 After the output handshake edge, in_ready=1 in the following cycle; the minimum issue interval is 9 cycles.

Reset
REQ-025 rst=1 SHALL force IDLE at once, without waiting for a clock edge.
REQ-026 During reset: in_ready=0, out_valid=0, xS=0, yS=0, sel=0, err=0, step counter=0, all captured operands=0.
REQ-027 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-028 Reset mid-operation (MUL, CMP or OUT) SHALL discard the transaction; no out_valid is produced for it.

Structure
REQ-029 Shared package trilat_pkg SHALL hold: N default, the FSM state enum, and width localparams for diff (N+3), square (2N+6), sum (2N+7) and err (2N+7).
REQ-030 One sub-module, sq_err_unit, SHALL hold the shared multiplier, the product registers and the abs-residual logic; the FSM, handshakes and selection stay in intersection_select.

Verification
REQ-031 Anchor (0,0), rM=5, candidates (3,4)/(6,8) -> out_valid 7 edges after accept; xS=3, yS=4, sel=0, err=0.
REQ-032 Anchor (0,0), rM=4, candidates (10,0)/(0,4) -> err1=84, err2=0; result (0,4), sel=1, err=0.
REQ-033 Tie: anchor (0,0), rM=3, candidates (5,0)/(0,5) -> both errors 16; result (5,0), sel=0, err=16.
REQ-034 Extremes, N=8: anchor (127,127), rM=0, candidates (-512,-512)/(511,511) -> err1=816642, err2=294912; result (511,511), sel=1, err=294912; no overflow.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid meanwhile -> outputs stable, in_ready=0, pulse ignored; release -> IDLE, and the next accept gives a correct result.
REQ-036 Assert rst during MUL step 3 -> all outputs 0 while rst=1; no out_valid follows; a fresh transaction after release matches REQ-031.
